// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - pipelined MEM stage with variable-latency data-memory handshake
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word accesses)
module mem_lsu_stage #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_IN,
  input  logic [31:0] Instr_IN,
  input  logic [31:0] PC_IN,
  input  logic [31:0] ALU_result_IN,
  input  logic [31:0] MemWriteData_IN,
  input  logic [4:0]  WriteRegister_IN,
  input  logic        RegWrite_IN,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic [5:0]  ALU_Control_IN,
  output logic        STALL_OUT,
  output logic        valid_OUT,
  output logic        RegWrite_OUT,
  output logic [4:0]  WriteRegister_OUT,
  output logic [31:0] WriteData_OUT,
  output logic [31:0] Instr_OUT,
  output logic [31:0] PC_OUT,
  output logic        DM_req,
  output logic        DM_we,
  output logic [31:0] DM_addr,
  output logic [3:0]  DM_be,
  output logic [31:0] DM_wdata,
  input  logic        DM_gnt,
  input  logic        DM_rvalid,
  input  logic [31:0] DM_rdata,
  output logic        MEM_ERR,
  output logic        EXC_ADDR
);
  localparam logic [5:0] OP_LB   = 6'b100001, OP_LH   = 6'b101011, OP_LBU  = 6'b101010;
  localparam logic [5:0] OP_LHU  = 6'b101100, OP_LW   = 6'b111101, OP_LL   = 6'b101000;
  localparam logic [5:0] OP_LWC1 = 6'b110101, OP_LWL  = 6'b101101, OP_LWR  = 6'b101110;
  localparam logic [5:0] OP_SB   = 6'b101111, OP_SH   = 6'b110000, OP_SW   = 6'b110001;
  localparam logic [5:0] OP_SC   = 6'b110110, OP_SWL  = 6'b110010, OP_SWR  = 6'b110011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, regwrite_q, mem_err_q;
  logic [4:0]           wreg_q;
  logic [31:0]          wdata_q, instr_q, pc_q;

  logic [1:0]  k;
  logic [4:0]  sh_k, sh_rk;
  logic        memop, live, misalign, trap, timeout;
  logic        req, st_done, ld_done, abort;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data, rd_shl, rd_shr, lo_mask, hi_mask;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // byte 0 is the most significant lane, so offset k shifts by 8k / 8(3-k)
  assign k       = ALU_result_IN[1:0];
  assign sh_k    = {k, 3'b000};
  assign sh_rk   = {~k, 3'b000};
  assign memop   = MemRead_IN | MemWrite_IN;
  assign live    = valid_IN & memop;
  assign timeout = (state_q != S_IDLE) && (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = live &&
                    ((((ALU_Control_IN == OP_LH) || (ALU_Control_IN == OP_LHU) ||
                       (ALU_Control_IN == OP_SH)) && k[0]) ||
                     (((ALU_Control_IN == OP_LW) || (ALU_Control_IN == OP_LL) ||
                       (ALU_Control_IN == OP_LWC1) || (ALU_Control_IN == OP_SW) ||
                       (ALU_Control_IN == OP_SC)) && (k != 2'b00)));
`else
  assign misalign = 1'b0;
`endif
  // a misaligned op never leaves IDLE, so the trap is only raised there
  assign trap = (state_q == S_IDLE) && misalign;

  // next-state, request and completion decode for the access handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    st_done = 1'b0;
    ld_done = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (live && !trap) begin
          req = 1'b1;
          if (!DM_gnt)          state_d = S_REQ;
          else if (MemWrite_IN) st_done = 1'b1;
          else                  state_d = S_WAIT_R;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        req   = live;
        if (live && DM_gnt && MemWrite_IN) begin
          st_done = 1'b1;
          state_d = S_IDLE;
        end else if (timeout || !live) begin
          abort   = timeout;
          state_d = S_IDLE;
        end else if (DM_gnt) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (DM_rvalid) begin
          ld_done = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // store byte enables and lane-positioned write data
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = MemWriteData_IN;
    case (ALU_Control_IN)
      OP_SB:        begin st_be = 4'b1000 >> k; st_wdata = {4{MemWriteData_IN[7:0]}};  end
      OP_SH:        begin st_be = 4'b1100 >> k; st_wdata = {2{MemWriteData_IN[15:0]}}; end
      OP_SWL:       begin st_be = 4'b1111 >> k; st_wdata = MemWriteData_IN >> sh_k;    end
      OP_SWR:       begin st_be = 4'b1111 << (~k); st_wdata = MemWriteData_IN << sh_rk; end
      OP_SW, OP_SC: begin st_be = 4'b1111; st_wdata = MemWriteData_IN;                 end
      default:      ;
    endcase
  end

  assign rd_shl  = DM_rdata << sh_k;
  assign rd_shr  = DM_rdata >> sh_rk;
  assign lo_mask = ~(32'hFFFF_FFFF << sh_k);
  assign hi_mask = ~(32'hFFFF_FFFF >> sh_rk);
  assign byte_v  = rd_shl[31:24];
  assign half_v  = k[1] ? DM_rdata[15:0] : DM_rdata[31:16];

  // load extraction, extension and LWL/LWR merge with the old rt value
  always_comb begin
    ld_data = DM_rdata;
    case (ALU_Control_IN)
      OP_LB:                ld_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:               ld_data = {24'd0, byte_v};
      OP_LH:                ld_data = {{16{half_v[15]}}, half_v};
      OP_LHU:               ld_data = {16'd0, half_v};
      OP_LWL:               ld_data = rd_shl | (MemWriteData_IN & lo_mask);
      OP_LWR:               ld_data = rd_shr | (MemWriteData_IN & hi_mask);
      OP_LW, OP_LL, OP_LWC1: ld_data = DM_rdata;
      default:              ;
    endcase
  end

  // reset gates the combinational outputs so a reset mid-access drops the request at once
  assign DM_req    = RESET & req;
  assign DM_we     = DM_req & MemWrite_IN;
  assign DM_addr   = DM_req ? {ALU_result_IN[31:2], 2'b00} : 32'd0;
  assign DM_be     = DM_req ? st_be : 4'd0;
  assign DM_wdata  = DM_we ? st_wdata : 32'd0;
  assign STALL_OUT = RESET & live & ~(st_done | ld_done | abort | trap);

  // FSM state and timeout counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: retire completed work, otherwise load a bubble
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wdata_q    <= 32'd0;
      instr_q    <= 32'd0;
      pc_q       <= 32'd0;
      mem_err_q  <= 1'b0;
    end else begin
      instr_q   <= Instr_IN;
      pc_q      <= PC_IN;
      mem_err_q <= abort;
      if ((valid_IN && !memop && state_q == S_IDLE) || st_done || ld_done) begin
        valid_q    <= 1'b1;
        regwrite_q <= RegWrite_IN;
        wreg_q     <= WriteRegister_IN;
        wdata_q    <= ld_done ? ld_data : ALU_result_IN;
      end else begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;
  // one-cycle address-exception pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) exc_q <= 1'b0;
    else        exc_q <= trap;
  end
  assign EXC_ADDR = exc_q;
`else
  assign EXC_ADDR = 1'b0;
`endif

  assign valid_OUT         = valid_q;
  assign RegWrite_OUT      = regwrite_q;
  assign WriteRegister_OUT = wreg_q;
  assign WriteData_OUT     = wdata_q;
  assign Instr_OUT         = instr_q;
  assign PC_OUT            = pc_q;
  assign MEM_ERR           = mem_err_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb/tb_mem_lsu_stage.sv - self-checking bench for mem_lsu_stage
module tb_mem_lsu_stage;
  localparam int TO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [5:0] C_LB   = 6'b100001, C_LH   = 6'b101011, C_LBU  = 6'b101010;
  localparam logic [5:0] C_LHU  = 6'b101100, C_LW   = 6'b111101, C_LL   = 6'b101000;
  localparam logic [5:0] C_LWC1 = 6'b110101, C_LWL  = 6'b101101, C_LWR  = 6'b101110;
  localparam logic [5:0] C_SB   = 6'b101111, C_SH   = 6'b110000, C_SW   = 6'b110001;
  localparam logic [5:0] C_SC   = 6'b110110, C_SWL  = 6'b110010, C_SWR  = 6'b110011;

  logic        CLK, RESET, valid_IN, RegWrite_IN, MemRead_IN, MemWrite_IN;
  logic [31:0] Instr_IN, PC_IN, ALU_result_IN, MemWriteData_IN, DM_rdata;
  logic [4:0]  WriteRegister_IN;
  logic [5:0]  ALU_Control_IN;
  logic        DM_gnt, DM_rvalid;
  logic        STALL_OUT, valid_OUT, RegWrite_OUT, DM_req, DM_we, MEM_ERR, EXC_ADDR;
  logic [4:0]  WriteRegister_OUT;
  logic [31:0] WriteData_OUT, Instr_OUT, PC_OUT, DM_addr, DM_wdata;
  logic [3:0]  DM_be;

  int n_assert = 0;
  int n_fail   = 0;

  mem_lsu_stage #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .Instr_IN(Instr_IN), .PC_IN(PC_IN),
    .ALU_result_IN(ALU_result_IN), .MemWriteData_IN(MemWriteData_IN),
    .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN),
    .MemWrite_IN(MemWrite_IN), .ALU_Control_IN(ALU_Control_IN), .STALL_OUT(STALL_OUT),
    .valid_OUT(valid_OUT), .RegWrite_OUT(RegWrite_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .WriteData_OUT(WriteData_OUT), .Instr_OUT(Instr_OUT), .PC_OUT(PC_OUT), .DM_req(DM_req),
    .DM_we(DM_we), .DM_addr(DM_addr), .DM_be(DM_be), .DM_wdata(DM_wdata), .DM_gnt(DM_gnt),
    .DM_rvalid(DM_rvalid), .DM_rdata(DM_rdata), .MEM_ERR(MEM_ERR), .EXC_ADDR(EXC_ADDR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_load(input logic [5:0] op);
    return op inside {C_LB, C_LH, C_LBU, C_LHU, C_LW, C_LL, C_LWC1, C_LWL, C_LWR};
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op inside {C_SB, C_SH, C_SW, C_SC, C_SWL, C_SWR};
  endfunction

  function automatic bit model_trap(input logic [5:0] op, input int k);
    bit mis;
    mis = ((op inside {C_LH, C_LHU, C_SH}) && (k % 2 == 1)) ||
          ((op inside {C_LW, C_LL, C_LWC1, C_SW, C_SC}) && (k != 0));
    return mis && TRAP_EN;
  endfunction

  // expected load result built byte by byte, byte 0 = most significant
  function automatic logic [31:0] exp_load(input logic [5:0] op, input int k,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  b[4];
    logic [7:0]  r[4];
    logic [7:0]  o[4];
    logic [15:0] h;
    logic [31:0] res;
    int hk;
    for (int i = 0; i < 4; i++) begin
      b[i] = rd[31-8*i -: 8];
      r[i] = rt[31-8*i -: 8];
    end
    hk = (k / 2) * 2;
    h  = {b[hk], b[hk+1]};
    res = rd;
    if (op == C_LB || op == C_LBU) begin
      res = {24'd0, b[k]};
      if (op == C_LB && b[k] >= 8'd128) res = res | 32'hFFFF_FF00;
    end else if (op == C_LH || op == C_LHU) begin
      res = {16'd0, h};
      if (op == C_LH && h >= 16'h8000) res = res | 32'hFFFF_0000;
    end else if (op == C_LWL || op == C_LWR) begin
      for (int i = 0; i < 4; i++) begin
        if (op == C_LWL) o[i] = (i + k < 4) ? b[i+k] : r[i];
        else             o[i] = (i >= 3 - k) ? b[i-3+k] : r[i];
      end
      res = {o[0], o[1], o[2], o[3]};
    end
    return res;
  endfunction

  function automatic bit lane_on(input logic [5:0] op, input int k, input int i);
    case (op)
      C_SB:    return i == k;
      C_SH:    return (i == k) || (i == k + 1);
      C_SWL:   return i >= k;
      C_SWR:   return i <= k;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] lane_byte(input logic [5:0] op, input int k, input int i,
                                           input logic [31:0] rt);
    logic [7:0] r[4];
    for (int j = 0; j < 4; j++) r[j] = rt[31-8*j -: 8];
    case (op)
      C_SB:    return r[3];
      C_SH:    return (i % 2 == 0) ? r[2] : r[3];
      C_SWL:   return (i >= k) ? r[i-k] : 8'd0;
      C_SWR:   return (i <= k) ? r[i+3-k] : 8'd0;
      default: return r[i];
    endcase
  endfunction

  task automatic set_idle();
    valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; RegWrite_IN = 1'b0;
    DM_gnt = 1'b0; DM_rvalid = 1'b0;
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [4:0] wreg);
    valid_IN = 1'b1; ALU_Control_IN = op; ALU_result_IN = addr; MemWriteData_IN = rt;
    MemRead_IN = is_load(op); MemWrite_IN = is_store(op); RegWrite_IN = is_load(op);
    WriteRegister_IN = wreg; Instr_IN = $urandom; PC_IN = $urandom;
  endtask

  task automatic do_nonmem(input logic [31:0] val, input logic rw);
    logic [31:0] ins;
    set_op(6'b000000, val, $urandom, 5'(int'($urandom_range(31, 0))));
    RegWrite_IN = rw;
    ins = Instr_IN;
    #1;
    chk1("nm_stall", STALL_OUT, 1'b0);
    chk1("nm_req", DM_req, 1'b0);
    @(negedge CLK);
    chk1("nm_valid", valid_OUT, 1'b1);
    chk1("nm_regwrite", RegWrite_OUT, rw);
    chk32("nm_wdata", WriteData_OUT, val);
    chk32("nm_instr", Instr_OUT, ins);
    set_idle();
  endtask

  task automatic do_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rd, input int gd, input int rvd, input bit junk);
    int k;
    logic [4:0]  wreg;
    logic [3:0]  ebe;
    logic [31:0] ewd, lmask;
    k    = int'(addr[1:0]);
    wreg = 5'(int'($urandom_range(31, 0)));
    set_op(op, addr, rt, wreg);
    if (model_trap(op, k)) begin
      DM_gnt = 1'b1;
      #1;
      chk1("trap_req", DM_req, 1'b0);
      chk1("trap_stall", STALL_OUT, 1'b0);
      @(negedge CLK);
      chk1("trap_exc", EXC_ADDR, 1'b1);
      chk1("trap_valid", valid_OUT, 1'b0);
      set_idle();
      return;
    end
    for (int c = 0; c < gd; c++) begin
      DM_gnt = 1'b0;
      #1;
      chk1("nognt_req", DM_req, 1'b1);
      chk1("nognt_stall", STALL_OUT, 1'b1);
      chk32("nognt_addr", DM_addr, {addr[31:2], 2'b00});
      @(negedge CLK);
      chk1("nognt_bubble", valid_OUT, 1'b0);
    end
    DM_gnt = 1'b1; DM_rvalid = junk; DM_rdata = ~rd;
    #1;
    chk1("gnt_req", DM_req, 1'b1);
    chk1("gnt_we", DM_we, is_store(op));
    chk32("gnt_addr", DM_addr, {addr[31:2], 2'b00});
    chk1("gnt_stall", STALL_OUT, !is_store(op));
    if (is_store(op)) begin
      ebe = 4'd0; ewd = 32'd0; lmask = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (lane_on(op, k, i)) begin
          ebe[3-i] = 1'b1;
          ewd[31-8*i -: 8]   = lane_byte(op, k, i, rt);
          lmask[31-8*i -: 8] = 8'hFF;
        end
      end
      chk32("st_be", {28'd0, DM_be}, {28'd0, ebe});
      chk32("st_wdata", DM_wdata & lmask, ewd);
    end
    @(negedge CLK);
    DM_gnt = 1'b0; DM_rvalid = 1'b0;
    if (is_store(op)) begin
      chk1("st_valid", valid_OUT, 1'b1);
      chk1("st_regwrite", RegWrite_OUT, 1'b0);
    end else begin
      chk1("ld_gnt_bubble", valid_OUT, 1'b0);
      for (int c = 0; c < rvd; c++) begin
        DM_rdata = $urandom;
        #1;
        chk1("wait_req", DM_req, 1'b0);
        chk1("wait_stall", STALL_OUT, 1'b1);
        @(negedge CLK);
        chk1("wait_bubble", valid_OUT, 1'b0);
      end
      DM_rvalid = 1'b1; DM_rdata = rd;
      #1;
      chk1("rv_stall", STALL_OUT, 1'b0);
      @(negedge CLK);
      DM_rvalid = 1'b0;
      chk1("ld_valid", valid_OUT, 1'b1);
      chk1("ld_regwrite", RegWrite_OUT, 1'b1);
      chk32("ld_wreg", {27'd0, WriteRegister_OUT}, {27'd0, wreg});
      chk32("ld_data", WriteData_OUT, exp_load(op, k, rd, rt));
      chk1("ld_memerr", MEM_ERR, 1'b0);
    end
    set_idle();
  endtask

  function automatic logic [5:0] pick_op(input int idx);
    case (idx)
      0: return C_LB;   1: return C_LH;   2: return C_LBU;  3: return C_LHU;
      4: return C_LW;   5: return C_LL;   6: return C_LWC1; 7: return C_LWL;
      8: return C_LWR;  9: return C_SB;  10: return C_SH;  11: return C_SW;
      12: return C_SC; 13: return C_SWL; 14: return C_SWR;
      default: return 6'b000000;
    endcase
  endfunction

  initial begin
    RESET = 1'b0; set_idle();
    Instr_IN = 0; PC_IN = 0; ALU_result_IN = 0; MemWriteData_IN = 0;
    WriteRegister_IN = 0; ALU_Control_IN = 0; DM_rdata = 0;
    @(negedge CLK); #1;
    chk1("rst_req", DM_req, 1'b0);
    chk1("rst_stall", STALL_OUT, 1'b0);
    chk1("rst_valid", valid_OUT, 1'b0);
    chk1("rst_regwrite", RegWrite_OUT, 1'b0);
    chk32("rst_wdata", WriteData_OUT, 32'd0);
    chk1("rst_memerr", MEM_ERR, 1'b0);
    chk1("rst_exc", EXC_ADDR, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    do_nonmem(32'h1234_5678, 1'b1);

    // SB 0x1003 with grant in the first cycle
    set_op(C_SB, 32'h0000_1003, 32'h0000_00AB, 5'd0);
    DM_gnt = 1'b1;
    #1;
    chk32("sb_addr", DM_addr, 32'h0000_1000);
    chk32("sb_be", {28'd0, DM_be}, 32'h1);
    chk32("sb_wdata", DM_wdata, 32'hABAB_ABAB);
    chk1("sb_stall", STALL_OUT, 1'b0);
    @(negedge CLK);
    set_idle();
    chk1("sb_valid", valid_OUT, 1'b1);
    #1;
    chk1("sb_idle_req", DM_req, 1'b0);

    do_mem(C_LWL, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 1'b0);
    chk32("lwl_value", WriteData_OUT, 32'hBBCC_DD44);
    do_mem(C_LH, 32'h0000_3002, 32'h0, 32'h1234_F00D, 0, 0, 1'b0);
    chk32("lh_value", WriteData_OUT, 32'hFFFF_F00D);
    do_mem(C_LHU, 32'h0000_3002, 32'h0, 32'h1234_F00D, 1, 0, 1'b1);
    chk32("lhu_value", WriteData_OUT, 32'h0000_F00D);

    // SWR 0x4001
    set_op(C_SWR, 32'h0000_4001, 32'hDEAD_BEEF, 5'd0);
    DM_gnt = 1'b1;
    #1;
    chk32("swr_be", {28'd0, DM_be}, 32'hC);
    chk32("swr_wdata_hi", {16'd0, DM_wdata[31:16]}, 32'h0000_BEEF);
    @(negedge CLK);
    set_idle();

    // bubble when valid_IN is low even with memory controls set
    set_op(C_LW, 32'h0000_7000, 32'h0, 5'd1);
    valid_IN = 1'b0;
    #1;
    chk1("inv_req", DM_req, 1'b0);
    chk1("inv_stall", STALL_OUT, 1'b0);
    @(negedge CLK);
    chk1("inv_bubble", valid_OUT, 1'b0);
    set_idle();

    // misaligned word load: trapped, or truncated to the word address
    set_op(C_LW, 32'h0000_5002, 32'h0, 5'd2);
    DM_gnt = 1'b1;
    #1;
    if (TRAP_EN) begin
      chk1("mis_trap_req", DM_req, 1'b0);
      @(negedge CLK);
      chk1("mis_trap_exc", EXC_ADDR, 1'b1);
      set_idle();
      @(negedge CLK);
      chk1("mis_trap_exc_clear", EXC_ADDR, 1'b0);
    end else begin
      chk1("mis_req", DM_req, 1'b1);
      chk32("mis_addr", DM_addr, 32'h0000_5000);
      @(negedge CLK);
      DM_gnt = 1'b0; DM_rvalid = 1'b1; DM_rdata = 32'hCAFE_F00D;
      chk1("mis_exc", EXC_ADDR, 1'b0);
      @(negedge CLK);
      chk32("mis_data", WriteData_OUT, 32'hCAFE_F00D);
      set_idle();
    end

    // load granted but never answered: abort after TO cycles in REQ+WAIT_R
    set_op(C_LW, 32'h0000_6000, 32'h0, 5'd3);
    DM_gnt = 1'b1;
    @(negedge CLK);
    DM_gnt = 1'b0;
    for (int c = 0; c < TO; c++) begin
      #1;
      chk1("to_stall", STALL_OUT, c != TO - 1);
      @(negedge CLK);
      if (c < TO - 1) chk1("to_no_err", MEM_ERR, 1'b0);
    end
    chk1("to_memerr", MEM_ERR, 1'b1);
    chk1("to_bubble", valid_OUT, 1'b0);
    do_nonmem(32'h0BAD_F00D, 1'b1);
    chk1("to_memerr_pulse", MEM_ERR, 1'b0);
    DM_rvalid = 1'b1; DM_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    DM_rvalid = 1'b0;
    chk1("late_rvalid_ignored", valid_OUT, 1'b0);
    chk32("late_rvalid_data", WriteData_OUT, 32'h0BAD_F00D);

    // response on the timeout edge wins
    set_op(C_LW, 32'h0000_6100, 32'h0, 5'd4);
    DM_gnt = 1'b1;
    @(negedge CLK);
    DM_gnt = 1'b0;
    repeat (TO - 1) @(negedge CLK);
    DM_rvalid = 1'b1; DM_rdata = 32'h5A5A_0001;
    @(negedge CLK);
    DM_rvalid = 1'b0;
    chk1("edge_valid", valid_OUT, 1'b1);
    chk1("edge_memerr", MEM_ERR, 1'b0);
    chk32("edge_data", WriteData_OUT, 32'h5A5A_0001);
    set_idle();

    // reset while waiting for read data
    set_op(C_LW, 32'h0000_6200, 32'h0, 5'd5);
    DM_gnt = 1'b1;
    @(negedge CLK);
    DM_gnt = 1'b0;
    RESET = 1'b0;
    #1;
    chk1("rstw_req", DM_req, 1'b0);
    chk1("rstw_stall", STALL_OUT, 1'b0);
    chk1("rstw_valid", valid_OUT, 1'b0);
    chk32("rstw_wdata", WriteData_OUT, 32'd0);
    @(negedge CLK);
    set_idle();
    RESET = 1'b1;
    @(negedge CLK);
    DM_rvalid = 1'b1;
    do_nonmem(32'h0000_0042, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = int'($urandom_range(15, 0));
      if (idx == 15) do_nonmem($urandom, 1'($urandom_range(1, 0)));
      else do_mem(pick_op(idx), $urandom, $urandom, $urandom,
                  int'($urandom_range(2, 0)), int'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
